// File: rtl/bbox_msg_reader.sv
// bbox_msg_reader: Avalon-MM master that drains bounding-box messages from the
// image-processor message port and presents one record per colour on a
// valid/ready stream.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   m_chipselect      bus chipselect, high only during an access cycle
//   m_read, m_write   single-cycle read / write strobes
//   m_address         word address (0 status, 1 message, 2 ID)
//   m_writedata       write data (flush command)
//   m_readdata        read data, fixed latency 1, no waitrequest
//   flush_req         message-buffer flush request pulse
//   box_valid/ready   record handshake
//   box_colour        0 red .. 5 fuchsia
//   box_x/y_min/max   record coordinates
//   box_present       non-empty box flag
//   id_error          sticky processor ID mismatch
//   set_count         completed 12-word message sets (wrapping)
module bbox_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter logic [31:0] EXPECTED_ID   = 32'h1234EEE2,
    parameter bit          ID_CHECK      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        flush_req,
    output logic        box_valid,
    input  logic        box_ready,
    output logic [2:0]  box_colour,
    output logic [10:0] box_x_min,
    output logic [10:0] box_y_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_max,
    output logic        box_present,
    output logic        id_error,
    output logic [15:0] set_count
);

    typedef enum logic [3:0] {
        StIdRd, StIdWait, StErr, StIdle, StFlush,
        StStRd, StStWait, StMsgRd, StMsgWait, StEmit
    } state_e;

    localparam state_e StReset = ID_CHECK ? StIdRd : StIdle;
    localparam int unsigned TimerW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TimerW-1:0] TimerReload = TimerW'(POLL_INTERVAL - 1);
    localparam logic [7:0] SetWords = 8'd12;
    localparam logic [31:0] FlushCmd = 32'h0000_0010;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               flush_q, flush_d;
    logic               cs_q, cs_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [2:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               valid_q, valid_d;
    logic [2:0]         colour_q, colour_d;
    logic               word_odd_q, word_odd_d;
    logic [10:0]        x_min_q, x_min_d, y_min_q, y_min_d;
    logic [10:0]        x_max_q, x_max_d, y_max_q, y_max_d;
    logic               id_error_q, id_error_d;
    logic [15:0]        set_count_q, set_count_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        flush_d     = flush_q | flush_req;
        valid_d     = valid_q;
        colour_d    = colour_q;
        word_odd_d  = word_odd_q;
        x_min_d     = x_min_q;
        y_min_d     = y_min_q;
        x_max_d     = x_max_q;
        y_max_d     = y_max_q;
        id_error_d  = id_error_q;
        set_count_d = set_count_q;

        unique case (state_q)
            // Stays one extra cycle so the registered strobe is issued after reset.
            StIdRd:    if (read_q) state_d = StIdWait;
            StIdWait: begin
                if (m_readdata == EXPECTED_ID) begin
                    state_d = StIdle;
                end else begin
                    id_error_d = 1'b1;
                    state_d    = StErr;
                end
            end
            StErr:     state_d = StErr;
            StIdle: begin
                if (flush_q) begin
                    // Flush wins; a timer already at zero polls right after it.
                    state_d = StFlush;
                    if (timer_q != '0) timer_d = timer_q - 1'b1;
                end else if (timer_q == '0) begin
                    state_d = StStRd;
                    timer_d = TimerReload;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StFlush: begin
                flush_d = flush_req;
                state_d = StIdle;
            end
            StStRd:    state_d = StStWait;
            StStWait: begin
                if (m_readdata[15:8] >= SetWords) begin
                    colour_d   = 3'd0;
                    word_odd_d = 1'b0;
                    state_d    = StMsgRd;
                end else begin
                    state_d = StIdle;
                end
            end
            StMsgRd:   state_d = StMsgWait;
            StMsgWait: begin
                if (!word_odd_q) begin
                    x_min_d    = m_readdata[26:16];
                    y_min_d    = m_readdata[10:0];
                    word_odd_d = 1'b1;
                    state_d    = StMsgRd;
                end else begin
                    x_max_d = m_readdata[26:16];
                    y_max_d = m_readdata[10:0];
                    valid_d = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (box_ready) begin
                    valid_d    = 1'b0;
                    word_odd_d = 1'b0;
                    if (colour_q == 3'd5) begin
                        colour_d    = 3'd0;
                        set_count_d = set_count_q + 16'd1;
                        state_d     = StIdle;
                    end else begin
                        colour_d = colour_q + 3'd1;
                        state_d  = StMsgRd;
                    end
                end
            end
            default:   state_d = StReset;
        endcase
    end

    // Bus strobes are registered: they are high exactly while the FSM sits in an access state.
    always_comb begin
        cs_d    = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = 3'd0;
        wdata_d = 32'h0;
        case (state_d)
            StIdRd: begin
                cs_d   = 1'b1;
                read_d = 1'b1;
                addr_d = 3'd2;
            end
            StStRd: begin
                cs_d   = 1'b1;
                read_d = 1'b1;
                addr_d = 3'd0;
            end
            StMsgRd: begin
                cs_d   = 1'b1;
                read_d = 1'b1;
                addr_d = 3'd1;
            end
            StFlush: begin
                cs_d    = 1'b1;
                write_d = 1'b1;
                addr_d  = 3'd0;
                wdata_d = FlushCmd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StReset;
            timer_q     <= TimerReload;
            flush_q     <= 1'b0;
            cs_q        <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 3'd0;
            wdata_q     <= 32'h0;
            valid_q     <= 1'b0;
            colour_q    <= 3'd0;
            word_odd_q  <= 1'b0;
            x_min_q     <= 11'd0;
            y_min_q     <= 11'd0;
            x_max_q     <= 11'd0;
            y_max_q     <= 11'd0;
            id_error_q  <= 1'b0;
            set_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            flush_q     <= flush_d;
            cs_q        <= cs_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            colour_q    <= colour_d;
            word_odd_q  <= word_odd_d;
            x_min_q     <= x_min_d;
            y_min_q     <= y_min_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            id_error_q  <= id_error_d;
            set_count_q <= set_count_d;
        end
    end

    assign m_chipselect = cs_q;
    assign m_read       = read_q;
    assign m_write      = write_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign box_valid    = valid_q;
    assign box_colour   = colour_q;
    assign box_x_min    = x_min_q;
    assign box_y_min    = y_min_q;
    assign box_x_max    = x_max_q;
    assign box_y_max    = y_max_q;
    assign box_present  = (x_min_q <= x_max_q) && (y_min_q <= y_max_q);
    assign id_error     = id_error_q;
    assign set_count    = set_count_q;

endmodule
